// File: rtl/wb_stage.sv
// Write-back stage: accepts ALU and load results, extends load data, buffers
// pending writes in a small FIFO and drains one per cycle into the register file.
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid_i,
  input  logic [4:0]               alu_rd_i,
  input  logic [XLEN-1:0]          alu_data_i,
  output logic                     alu_ready_o,
  input  logic                     lsu_valid_i,
  input  logic [4:0]               lsu_rd_i,
  input  logic [XLEN-1:0]          lsu_data_i,
  input  logic [2:0]               lsu_funct3_i,
  input  logic [1:0]               lsu_addr_lo_i,
  output logic                     lsu_ready_o,
  input  logic                     wb_hold_i,
  output logic [4:0]               w_reg_o,
  output logic [XLEN-1:0]          w_data_o,
  output logic                     RegWEn_o,
  input  logic [4:0]               hz_rs1_i,
  input  logic [4:0]               hz_rs2_i,
  output logic                     hz_stall_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [PW-1:0]   rptr, wptr;
  logic [CW-1:0]   count;

  logic            pop, space;
  logic            lsu_fire, alu_fire, store;
  logic [4:0]      enq_rd;
  logic [XLEN-1:0] enq_data;
  logic [XLEN-1:0] load_ext;
  logic [7:0]      load_byte;
  logic [15:0]     load_half;

  assign pop         = (count != '0) && !wb_hold_i;
  assign space       = (count < CW'(DEPTH)) || pop;
  assign lsu_ready_o = space;
  assign alu_ready_o = space && !lsu_valid_i;

  assign lsu_fire = lsu_valid_i && lsu_ready_o;
  assign alu_fire = alu_valid_i && alu_ready_o;

  // Halfword select uses only the upper offset bit; misaligned halves are not split.
  assign load_byte = lsu_data_i[{lsu_addr_lo_i, 3'b000} +: 8];
  assign load_half = lsu_data_i[{lsu_addr_lo_i[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = lsu_data_i;
    case (lsu_funct3_i)
      3'b000:  load_ext = {{(XLEN-8){load_byte[7]}}, load_byte};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, load_byte};
      3'b001:  load_ext = {{(XLEN-16){load_half[15]}}, load_half};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, load_half};
      default: load_ext = lsu_data_i;
    endcase
  end

  always_comb begin
    enq_rd   = '0;
    enq_data = '0;
    if (lsu_fire) begin
      enq_rd   = lsu_rd_i;
      enq_data = load_ext;
    end else if (alu_fire) begin
      enq_rd   = alu_rd_i;
      enq_data = alu_data_i;
    end
  end

  // Writes to x0 complete the handshake but never occupy an entry.
  assign store = (lsu_fire || alu_fire) && (enq_rd != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (store) begin
        rd_q[wptr]   <= enq_rd;
        data_q[wptr] <= enq_data;
        wptr         <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({store, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign RegWEn_o = pop;
  assign w_reg_o  = (count != '0) ? rd_q[rptr]   : '0;
  assign w_data_o = (count != '0) ? data_q[rptr] : '0;
  assign count_o  = count;

  always_comb begin
    logic [PW-1:0] offs;
    hz_stall_o = 1'b0;
    offs       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = PW'(i) - rptr;
      if ({1'b0, offs} < count) begin
        if ((hz_rs1_i != 5'd0 && rd_q[i] == hz_rs1_i) ||
            (hz_rs2_i != 5'd0 && rd_q[i] == hz_rs2_i)) begin
          hz_stall_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: load-extension vector table, directed
// corner sequences and randomized traffic against a queue-based reference.
module tb_wb_stage;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid_i, lsu_valid_i, wb_hold_i;
  logic [4:0]  alu_rd_i, lsu_rd_i, hz_rs1_i, hz_rs2_i;
  logic [31:0] alu_data_i, lsu_data_i;
  logic [2:0]  lsu_funct3_i;
  logic [1:0]  lsu_addr_lo_i;
  logic        alu_ready_o, lsu_ready_o, RegWEn_o, hz_stall_o;
  logic [4:0]  w_reg_o;
  logic [31:0] w_data_o;
  logic [$clog2(DEPTH):0] count_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;
  entry_t mq[$];

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] word;
    logic [31:0] exp;
  } ld_vec_t;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .lsu_funct3_i(lsu_funct3_i), .lsu_addr_lo_i(lsu_addr_lo_i),
    .lsu_ready_o(lsu_ready_o),
    .wb_hold_i(wb_hold_i),
    .w_reg_o(w_reg_o), .w_data_o(w_data_o), .RegWEn_o(RegWEn_o),
    .hz_rs1_i(hz_rs1_i), .hz_rs2_i(hz_rs2_i), .hz_stall_o(hz_stall_o),
    .count_o(count_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [2:0] f,
                                          input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'h0000_00FF;
    h = (w >> (16 * off[1])) & 32'h0000_FFFF;
    case (f)
      3'b000:  return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic idle();
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    alu_rd_i = '0; lsu_rd_i = '0; alu_data_i = '0; lsu_data_i = '0;
    lsu_funct3_i = 3'b010; lsu_addr_lo_i = '0;
  endtask

  // Called just after a falling edge with inputs applied: checks every output
  // against the queue model, then advances the model across the rising edge.
  task automatic run_cycle();
    int     sz;
    logic   e_pop, e_space, e_ar, e_stall, enq;
    entry_t ne;
    #1;
    sz      = mq.size();
    e_pop   = (sz != 0) && !wb_hold_i;
    e_space = (sz < DEPTH) || e_pop;
    e_ar    = e_space && !lsu_valid_i;
    e_stall = 1'b0;
    foreach (mq[k])
      if ((hz_rs1_i != 0 && mq[k].rd == hz_rs1_i) || (hz_rs2_i != 0 && mq[k].rd == hz_rs2_i))
        e_stall = 1'b1;
    chk("RegWEn", {31'b0, RegWEn_o}, {31'b0, e_pop});
    chk("w_reg", {27'b0, w_reg_o}, sz != 0 ? {27'b0, mq[0].rd} : 32'h0);
    chk("w_data", w_data_o, sz != 0 ? mq[0].data : 32'h0);
    chk("count", 32'(count_o), 32'(sz));
    chk("lsu_ready", {31'b0, lsu_ready_o}, {31'b0, e_space});
    chk("alu_ready", {31'b0, alu_ready_o}, {31'b0, e_ar});
    chk("stall", {31'b0, hz_stall_o}, {31'b0, e_stall});
    enq = 1'b0;
    ne  = '{rd: 5'd0, data: 32'h0};
    if (lsu_valid_i && e_space) begin
      enq = 1'b1; ne = '{rd: lsu_rd_i, data: ref_ext(lsu_data_i, lsu_funct3_i, lsu_addr_lo_i)};
    end else if (alu_valid_i && e_ar) begin
      enq = 1'b1; ne = '{rd: alu_rd_i, data: alu_data_i};
    end
    @(posedge clk);
    if (e_pop) void'(mq.pop_front());
    if (enq && ne.rd != 0) mq.push_back(ne);
    @(negedge clk);
  endtask

  task automatic alu_push(input logic [4:0] rd, input logic [31:0] d);
    idle(); alu_valid_i = 1'b1; alu_rd_i = rd; alu_data_i = d;
  endtask

  ld_vec_t lv[12];

  initial begin
    lv[0]  = '{3'b000, 2'd1, 32'h80FF_7F01, 32'h0000_007F};
    lv[1]  = '{3'b000, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80};
    lv[2]  = '{3'b100, 2'd2, 32'h80FF_7F01, 32'h0000_00FF};
    lv[3]  = '{3'b001, 2'd2, 32'h80FF_7F01, 32'hFFFF_80FF};
    lv[4]  = '{3'b101, 2'd0, 32'h80FF_7F01, 32'h0000_7F01};
    lv[5]  = '{3'b010, 2'd0, 32'h80FF_7F01, 32'h80FF_7F01};
    lv[6]  = '{3'b001, 2'd3, 32'h80FF_7F01, 32'hFFFF_80FF};
    lv[7]  = '{3'b101, 2'd2, 32'h80FF_7F01, 32'h0000_80FF};
    lv[8]  = '{3'b100, 2'd3, 32'h80FF_7F01, 32'h0000_0080};
    lv[9]  = '{3'b000, 2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF};
    lv[10] = '{3'b011, 2'd1, 32'h80FF_7F01, 32'h80FF_7F01};
    lv[11] = '{3'b111, 2'd3, 32'h1234_5678, 32'h1234_5678};

    rst = 1'b0; wb_hold_i = 1'b0; hz_rs1_i = '0; hz_rs2_i = '0; idle();
    #2;
    chk("rst_count", 32'(count_o), 0);
    chk("rst_we", {31'b0, RegWEn_o}, 0);
    chk("rst_stall", {31'b0, hz_stall_o}, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    // Basic write
    alu_push(5'd5, 32'h1234_5678); run_cycle();
    idle(); #1;
    chk("basic_we", {31'b0, RegWEn_o}, 1);
    chk("basic_reg", {27'b0, w_reg_o}, 5);
    chk("basic_data", w_data_o, 32'h1234_5678);
    run_cycle();
    run_cycle();
    chk("basic_drain", 32'(count_o), 0);

    // Load extension table
    for (int i = 0; i < 12; i++) begin
      idle(); lsu_valid_i = 1'b1; lsu_rd_i = 5'd3;
      lsu_data_i = lv[i].word; lsu_funct3_i = lv[i].f3; lsu_addr_lo_i = lv[i].off;
      run_cycle();
      idle(); #1;
      chk($sformatf("ldext%0d", i), w_data_o, lv[i].exp);
      run_cycle();
    end

    // Priority and x0
    alu_push(5'd9, 32'hAAAA_0009);
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd10; lsu_data_i = 32'h5555_000A; lsu_funct3_i = 3'b010;
    #1; chk("prio_alu_ready", {31'b0, alu_ready_o}, 0);
    run_cycle();
    lsu_valid_i = 1'b0; lsu_rd_i = '0;
    #1; chk("prio_alu_next", {31'b0, alu_ready_o}, 1);
    run_cycle();
    idle(); run_cycle(); run_cycle();
    alu_push(5'd0, 32'hDEAD_BEEF); run_cycle();
    idle(); #1;
    chk("x0_count", 32'(count_o), 0);
    chk("x0_we", {31'b0, RegWEn_o}, 0);
    run_cycle();

    // Hold, full, then enqueue into full FIFO while draining
    wb_hold_i = 1'b1;
    alu_push(5'd1, 32'h11); run_cycle();
    alu_push(5'd2, 32'h22); run_cycle();
    idle(); alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_data_i = 32'h44; #1;
    chk("full_count", 32'(count_o), 2);
    chk("full_lsu_rdy", {31'b0, lsu_ready_o}, 0);
    chk("full_alu_rdy", {31'b0, alu_ready_o}, 0);
    run_cycle();
    wb_hold_i = 1'b0; alu_push(5'd3, 32'h33); #1;
    chk("fullpop_rdy", {31'b0, alu_ready_o}, 1);
    chk("fullpop_reg", {27'b0, w_reg_o}, 1);
    run_cycle();
    idle(); #1; chk("order2", {27'b0, w_reg_o}, 2);
    run_cycle();
    #1; chk("order3", {27'b0, w_reg_o}, 3);
    run_cycle(); run_cycle();

    // Hazard
    wb_hold_i = 1'b1; alu_push(5'd7, 32'h77); run_cycle();
    idle(); hz_rs1_i = 5'd7; #1; chk("hz_rs1", {31'b0, hz_stall_o}, 1);
    run_cycle();
    hz_rs1_i = 5'd0; hz_rs2_i = 5'd7; #1; chk("hz_rs2", {31'b0, hz_stall_o}, 1);
    run_cycle();
    hz_rs2_i = 5'd0; #1; chk("hz_x0", {31'b0, hz_stall_o}, 0);
    run_cycle();
    wb_hold_i = 1'b0; hz_rs1_i = 5'd7; #1; chk("hz_head", {31'b0, hz_stall_o}, 1);
    run_cycle();
    #1; chk("hz_clear", {31'b0, hz_stall_o}, 0);
    run_cycle();
    hz_rs1_i = '0;

    // Async reset with two pending entries
    wb_hold_i = 1'b1;
    alu_push(5'd12, 32'hC); run_cycle();
    alu_push(5'd13, 32'hD); run_cycle();
    idle(); hz_rs1_i = 5'd12;
    #2; rst = 1'b0; #1;
    chk("arst_count", 32'(count_o), 0);
    chk("arst_reg", {27'b0, w_reg_o}, 0);
    chk("arst_data", w_data_o, 0);
    chk("arst_stall", {31'b0, hz_stall_o}, 0);
    rst = 1'b1; mq.delete();
    @(negedge clk);
    wb_hold_i = 1'b0; hz_rs1_i = '0;
    run_cycle(); run_cycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      alu_valid_i   = ($urandom_range(0, 99) < 50);
      lsu_valid_i   = ($urandom_range(0, 99) < 35);
      alu_rd_i      = 5'($urandom_range(0, 7));
      lsu_rd_i      = 5'($urandom_range(0, 7));
      alu_data_i    = $urandom;
      lsu_data_i    = $urandom;
      lsu_funct3_i  = 3'($urandom_range(0, 7));
      lsu_addr_lo_i = 2'($urandom_range(0, 3));
      wb_hold_i     = ($urandom_range(0, 99) < 25);
      hz_rs1_i      = 5'($urandom_range(0, 7));
      hz_rs2_i      = 5'($urandom_range(0, 7));
      run_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
